// File: rtl/cache_tag_query_assoc.sv
// -----------------------------------------------------------------------------
// cache_tag_query_assoc
//
// N-way set-associative tag lookup for the L1 caches. Each way keeps a tag RAM
// (registered read) plus a per-set valid bit held in flops so that reset and the
// invalidate sweep can clear them. Lookups run through a two-stage pipeline:
// S1 captures the request together with every way's tag/valid for the set, the
// compare happens combinationally during the following cycle, and the result is
// registered into the output stage.
//
// Optional feature macro: CACHE_TAG_PLRU_EN
//   defined   -> tree pseudo-LRU replacement (NUM_WAYS-1 bits per set), updated
//                on every hit captured into the output stage and on every fill.
//   undefined -> per-set round-robin pointer, advanced only by fills that had to
//                evict a valid way; hits leave it alone.
//
// Ports
//   clock_i, reset_i (async, active-low)
//   flush_i          kill in-flight lookups (wins over stall_i)
//   stall_i          freeze S1 and the output stage
//   lookupEnable_i, tag_i, index_i, offset_i           lookup request
//   updateEnable_i, updateTag_i, updateIndex_i         fill request
//   invalidateAll_i  start a one-set-per-cycle invalidate sweep
//   tag_o, index_o, offset_o, enable_o, hit_o, hitWay_o lookup result
//   updateWay_o      way chosen by the most recent accepted fill
//   busy_o           sweep in progress
// -----------------------------------------------------------------------------
module cache_tag_query_assoc #(
  parameter int OFFSET_SIZE = 5,
  parameter int INDEX_SIZE  = 6,
  parameter int TAG_SIZE    = 64 - (OFFSET_SIZE + INDEX_SIZE),
  parameter int NUM_WAYS    = 4,
  parameter int WAY_BITS    = $clog2(NUM_WAYS)
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   stall_i,
  input  logic                   lookupEnable_i,
  input  logic [TAG_SIZE-1:0]    tag_i,
  input  logic [INDEX_SIZE-1:0]  index_i,
  input  logic [OFFSET_SIZE-1:0] offset_i,
  input  logic                   updateEnable_i,
  input  logic [TAG_SIZE-1:0]    updateTag_i,
  input  logic [INDEX_SIZE-1:0]  updateIndex_i,
  input  logic                   invalidateAll_i,
  output logic [TAG_SIZE-1:0]    tag_o,
  output logic [INDEX_SIZE-1:0]  index_o,
  output logic [OFFSET_SIZE-1:0] offset_o,
  output logic                   enable_o,
  output logic                   hit_o,
  output logic [WAY_BITS-1:0]    hitWay_o,
  output logic [WAY_BITS-1:0]    updateWay_o,
  output logic                   busy_o
);

  localparam int SETS = 1 << INDEX_SIZE;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                  state_reg, state_next;
  logic [INDEX_SIZE-1:0]   sweep_idx_reg, sweep_idx_next;

  logic [NUM_WAYS-1:0]     valid_reg [SETS];

  logic                    s1_valid_reg;
  logic [TAG_SIZE-1:0]     s1_tag_reg;
  logic [INDEX_SIZE-1:0]   s1_index_reg;
  logic [OFFSET_SIZE-1:0]  s1_offset_reg;
  logic [NUM_WAYS-1:0]     rd_valid_reg;

  logic                    fill_fire;
  logic                    accept;
  logic [NUM_WAYS-1:0]     fill_row;
  logic                    inv_found;
  logic [WAY_BITS-1:0]     inv_way;
  logic [WAY_BITS-1:0]     policy_way;
  logic [WAY_BITS-1:0]     fill_way;
  logic [NUM_WAYS-1:0]     hit_vec;
  logic                    hit_any;
  logic [WAY_BITS-1:0]     hit_way;

  assign busy_o    = (state_reg == SWEEP);
  assign fill_fire = updateEnable_i & ~busy_o;
  // A fill owns the tag arrays for its cycle, so a coincident lookup is refused.
  assign accept    = lookupEnable_i & ~updateEnable_i & ~stall_i & ~busy_o & ~flush_i;

  // ---------------------------------------------------------------------------
  // Victim selection: lowest invalid way first, otherwise the replacement policy.
  // ---------------------------------------------------------------------------
  assign fill_row = valid_reg[updateIndex_i];

  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!fill_row[w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(w);
      end
    end
  end

  assign fill_way = inv_found ? inv_way : policy_way;

`ifdef CACHE_TAG_PLRU_EN
  // Tree nodes are stored heap-style: node n has children 2n+1 (left) and
  // 2n+2 (right). A node bit of 1 means the victim lies in the right subtree.
  logic [NUM_WAYS-2:0] plru_reg [SETS];
  logic                hit_capture;

  function automatic logic [WAY_BITS-1:0] plru_victim(input logic [NUM_WAYS-2:0] t);
    logic [WAY_BITS-1:0] v;
    logic                b;
    int                  n;
    v = '0;
    n = 0;
    for (int l = 0; l < WAY_BITS; l++) begin
      b = 1'b0;
      for (int k = 0; k < NUM_WAYS - 1; k++) begin
        if (k == n) b = t[k];
      end
      v = (v << 1) | WAY_BITS'(b);
      n = 2 * n + 1 + int'(b);
    end
    return v;
  endfunction

  // Point every node on the path to way w away from it.
  function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] t,
                                                     input logic [WAY_BITS-1:0] w);
    logic [NUM_WAYS-2:0] r;
    logic                d;
    int                  n;
    r = t;
    n = 0;
    for (int l = 0; l < WAY_BITS; l++) begin
      d = ((w >> (WAY_BITS - 1 - l)) & WAY_BITS'(1)) != '0;
      for (int k = 0; k < NUM_WAYS - 1; k++) begin
        if (k == n) r[k] = ~d;
      end
      n = 2 * n + 1 + int'(d);
    end
    return r;
  endfunction

  assign policy_way  = plru_victim(plru_reg[updateIndex_i]);
  assign hit_capture = ~flush_i & ~stall_i & s1_valid_reg & hit_any;

  // Later assignments win when a hit, a fill and the sweep target the same set.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int s = 0; s < SETS; s++) plru_reg[s] <= '0;
    end else begin
      if (hit_capture)
        plru_reg[s1_index_reg] <= plru_touch(plru_reg[s1_index_reg], hit_way);
      if (fill_fire)
        plru_reg[updateIndex_i] <= plru_touch(plru_reg[updateIndex_i], fill_way);
      if (busy_o)
        plru_reg[sweep_idx_reg] <= '0;
    end
  end
`else
  logic [WAY_BITS-1:0] rr_ptr_reg [SETS];

  assign policy_way = rr_ptr_reg[updateIndex_i];

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int s = 0; s < SETS; s++) rr_ptr_reg[s] <= '0;
    end else begin
      // Only evictions advance the pointer; filling an empty way does not.
      if (fill_fire && !inv_found)
        rr_ptr_reg[updateIndex_i] <= rr_ptr_reg[updateIndex_i] + WAY_BITS'(1);
      if (busy_o)
        rr_ptr_reg[sweep_idx_reg] <= '0;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Valid bits: fill sets, sweep clears one whole set per cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int s = 0; s < SETS; s++) valid_reg[s] <= '0;
    end else begin
      if (fill_fire)
        valid_reg[updateIndex_i][fill_way] <= 1'b1;
      if (busy_o)
        valid_reg[sweep_idx_reg] <= '0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) updateWay_o <= '0;
    else if (fill_fire) updateWay_o <= fill_way;
  end

  // ---------------------------------------------------------------------------
  // Per-way tag RAM with registered read, and the per-way compare.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
      logic [TAG_SIZE-1:0] tag_mem [SETS];
      logic [TAG_SIZE-1:0] rd_tag_reg;

      always_ff @(posedge clock_i) begin
        if (fill_fire && (fill_way == WAY_BITS'(gi)))
          tag_mem[updateIndex_i] <= updateTag_i;
        if (accept)
          rd_tag_reg <= tag_mem[index_i];
      end

      assign hit_vec[gi] = rd_valid_reg[gi] && (rd_tag_reg == s1_tag_reg);
    end
  endgenerate

  // Lowest matching way wins if several ways carry the same tag.
  always_comb begin
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_BITS'(w);
    end
  end

  assign hit_any = |hit_vec;

  // ---------------------------------------------------------------------------
  // Lookup pipeline: S1 request + read data, then the registered result.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      s1_valid_reg  <= 1'b0;
      s1_tag_reg    <= '0;
      s1_index_reg  <= '0;
      s1_offset_reg <= '0;
      rd_valid_reg  <= '0;
      enable_o      <= 1'b0;
      hit_o         <= 1'b0;
      hitWay_o      <= '0;
      tag_o         <= '0;
      index_o       <= '0;
      offset_o      <= '0;
    end else if (flush_i) begin
      s1_valid_reg <= 1'b0;
      enable_o     <= 1'b0;
    end else if (!stall_i) begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_tag_reg    <= tag_i;
        s1_index_reg  <= index_i;
        s1_offset_reg <= offset_i;
        rd_valid_reg  <= valid_reg[index_i];
      end
      enable_o <= s1_valid_reg;
      hit_o    <= s1_valid_reg & hit_any;
      hitWay_o <= (s1_valid_reg & hit_any) ? hit_way : '0;
      tag_o    <= s1_tag_reg;
      index_o  <= s1_index_reg;
      offset_o <= s1_offset_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Invalidate sweep FSM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_reg     <= IDLE;
      sweep_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      sweep_idx_reg <= sweep_idx_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sweep_idx_next = sweep_idx_reg;
    case (state_reg)
      IDLE: begin
        if (invalidateAll_i) begin
          state_next     = SWEEP;
          sweep_idx_next = '0;
        end
      end
      SWEEP: begin
        if (sweep_idx_reg == INDEX_SIZE'(SETS - 1)) begin
          state_next     = IDLE;
          sweep_idx_next = '0;
        end else begin
          sweep_idx_next = sweep_idx_reg + INDEX_SIZE'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_tag_query_assoc.sv
// -----------------------------------------------------------------------------
// Directed testbench for cache_tag_query_assoc (NUM_WAYS=4, INDEX_SIZE=6).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_cache_tag_query_assoc;

  localparam int OFFSET_SIZE = 5;
  localparam int INDEX_SIZE  = 6;
  localparam int TAG_SIZE    = 64 - (OFFSET_SIZE + INDEX_SIZE);
  localparam int NUM_WAYS    = 4;
  localparam int WAY_BITS    = 2;

`ifdef CACHE_TAG_PLRU_EN
  localparam logic [WAY_BITS-1:0] SIXTH_WAY = 2'd2;
`else
  localparam logic [WAY_BITS-1:0] SIXTH_WAY = 2'd1;
`endif

  logic                   clk;
  logic                   rst_n;
  logic                   flush;
  logic                   stall;
  logic                   lookup_en;
  logic [TAG_SIZE-1:0]    tag;
  logic [INDEX_SIZE-1:0]  idx;
  logic [OFFSET_SIZE-1:0] off;
  logic                   upd_en;
  logic [TAG_SIZE-1:0]    upd_tag;
  logic [INDEX_SIZE-1:0]  upd_idx;
  logic                   inv_all;
  logic [TAG_SIZE-1:0]    tag_o;
  logic [INDEX_SIZE-1:0]  index_o;
  logic [OFFSET_SIZE-1:0] offset_o;
  logic                   enable_o;
  logic                   hit_o;
  logic [WAY_BITS-1:0]    hit_way_o;
  logic [WAY_BITS-1:0]    upd_way_o;
  logic                   busy_o;

  int checks = 0;
  int errors = 0;

  cache_tag_query_assoc #(
    .OFFSET_SIZE(OFFSET_SIZE),
    .INDEX_SIZE (INDEX_SIZE),
    .TAG_SIZE   (TAG_SIZE),
    .NUM_WAYS   (NUM_WAYS),
    .WAY_BITS   (WAY_BITS)
  ) dut (
    .clock_i        (clk),
    .reset_i        (rst_n),
    .flush_i        (flush),
    .stall_i        (stall),
    .lookupEnable_i (lookup_en),
    .tag_i          (tag),
    .index_i        (idx),
    .offset_i       (off),
    .updateEnable_i (upd_en),
    .updateTag_i    (upd_tag),
    .updateIndex_i  (upd_idx),
    .invalidateAll_i(inv_all),
    .tag_o          (tag_o),
    .index_o        (index_o),
    .offset_o       (offset_o),
    .enable_o       (enable_o),
    .hit_o          (hit_o),
    .hitWay_o       (hit_way_o),
    .updateWay_o    (upd_way_o),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Fill one line; updateWay_o is checked right after the writing edge.
  task automatic fill_chk(input string name, input logic [TAG_SIZE-1:0] t,
                          input logic [INDEX_SIZE-1:0] i, input logic [WAY_BITS-1:0] exp_way);
    upd_en  = 1'b1;
    upd_tag = t;
    upd_idx = i;
    tick();
    upd_en = 1'b0;
    $display("txn fill   tag=0x%0h idx=%0d way=%0d", t, i, upd_way_o);
    chk({name, ".way"}, 64'(upd_way_o), 64'(exp_way));
  endtask

  // Accepted lookup; result is checked two edges after acceptance request.
  task automatic lookup_chk(input string name, input logic [TAG_SIZE-1:0] t,
                            input logic [INDEX_SIZE-1:0] i, input logic exp_hit,
                            input logic [WAY_BITS-1:0] exp_way);
    lookup_en = 1'b1;
    tag       = t;
    idx       = i;
    off       = 5'd7;
    tick();
    lookup_en = 1'b0;
    tick();
    $display("txn lookup tag=0x%0h idx=%0d en=%0b hit=%0b way=%0d", t, i, enable_o, hit_o, hit_way_o);
    chk({name, ".en"},  64'(enable_o),  64'(1'b1));
    chk({name, ".hit"}, 64'(hit_o),     64'(exp_hit));
    chk({name, ".way"}, 64'(hit_way_o), 64'(exp_way));
    chk({name, ".tag"}, 64'(tag_o),     64'(t));
  endtask

  initial begin
    int cnt;
    logic saw_en;

    rst_n = 1'b0; flush = 1'b0; stall = 1'b0; lookup_en = 1'b0;
    tag = '0; idx = '0; off = '0; upd_en = 1'b0; upd_tag = '0; upd_idx = '0; inv_all = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst.en",   64'(enable_o),  64'(0));
    chk("rst.hit",  64'(hit_o),     64'(0));
    chk("rst.busy", 64'(busy_o),    64'(0));
    chk("rst.uway", 64'(upd_way_o), 64'(0));
    chk("rst.tag",  64'(tag_o),     64'(0));
    rst_n = 1'b1;
    tick();

    // Cold miss, offset and index carried through
    lookup_en = 1'b1; tag = 53'h123; idx = 6'd5; off = 5'd3;
    tick();
    lookup_en = 1'b0;
    tick();
    $display("txn lookup tag=0x123 idx=5 en=%0b hit=%0b", enable_o, hit_o);
    chk("miss.en",  64'(enable_o),  64'(1));
    chk("miss.hit", 64'(hit_o),     64'(0));
    chk("miss.way", 64'(hit_way_o), 64'(0));
    chk("miss.off", 64'(offset_o),  64'(3));
    chk("miss.idx", 64'(index_o),   64'(5));
    tick();
    chk("miss.en_drop", 64'(enable_o), 64'(0));

    // Fill, then read-after-fill in the very next cycle
    fill_chk("fill123", 53'h123, 6'd5, 2'd0);
    lookup_chk("raf", 53'h123, 6'd5, 1'b1, 2'd0);

    // Fill and lookup in the same cycle: fill proceeds, lookup is dropped
    upd_en = 1'b1; upd_tag = 53'h55; upd_idx = 6'd30;
    lookup_en = 1'b1; tag = 53'h55; idx = 6'd30;
    tick();
    upd_en = 1'b0; lookup_en = 1'b0;
    chk("same.uway", 64'(upd_way_o), 64'(0));
    tick();
    chk("same.en", 64'(enable_o), 64'(0));

    // Five fills to set 9, then eviction choice for a sixth
    fill_chk("f9_1", 53'd1, 6'd9, 2'd0);
    fill_chk("f9_2", 53'd2, 6'd9, 2'd1);
    fill_chk("f9_3", 53'd3, 6'd9, 2'd2);
    fill_chk("f9_4", 53'd4, 6'd9, 2'd3);
    fill_chk("f9_5", 53'd5, 6'd9, 2'd0);
    lookup_chk("l9_t1", 53'd1, 6'd9, 1'b0, 2'd0);
    lookup_chk("l9_t5", 53'd5, 6'd9, 1'b1, 2'd0);
    fill_chk("f9_6", 53'd6, 6'd9, SIXTH_WAY);
    lookup_chk("l9_t6", 53'd6, 6'd9, 1'b1, SIXTH_WAY);

    // Back-to-back lookups, then stall with the second one sitting in S1
    lookup_en = 1'b1; tag = 53'd6; idx = 6'd9; off = 5'd1;
    tick();
    tag = 53'h123; idx = 6'd5; off = 5'd2;
    tick();
    chk("b2b.en",  64'(enable_o),  64'(1));
    chk("b2b.tag", 64'(tag_o),     64'(6));
    stall = 1'b1; tag = 53'h999; idx = 6'd9;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall.en",  64'(enable_o),  64'(1));
      chk("stall.tag", 64'(tag_o),     64'(6));
      chk("stall.way", 64'(hit_way_o), 64'(SIXTH_WAY));
    end
    stall = 1'b0; lookup_en = 1'b0;
    tick();
    chk("unstall.tag", 64'(tag_o),     64'(53'h123));
    chk("unstall.hit", 64'(hit_o),     64'(1));
    chk("unstall.way", 64'(hit_way_o), 64'(0));
    chk("unstall.off", 64'(offset_o),  64'(2));

    // Flush while stalled kills the output and the lookup in S1
    lookup_en = 1'b1; tag = 53'h123; idx = 6'd5;
    tick();
    lookup_en = 1'b0; stall = 1'b1; flush = 1'b1;
    tick();
    chk("flush.en", 64'(enable_o), 64'(0));
    stall = 1'b0; flush = 1'b0;
    tick();
    chk("flush.s1", 64'(enable_o), 64'(0));

    // Invalidate sweep: busy for exactly 64 cycles, fills/lookups dropped
    inv_all = 1'b1;
    tick();
    inv_all = 1'b0;
    chk("sweep.busy", 64'(busy_o), 64'(1));
    cnt = 1;
    saw_en = 1'b0;
    for (int c = 0; c < 200 && busy_o === 1'b1; c++) begin
      if (c % 2 == 0) begin
        upd_en = 1'b1; upd_tag = 53'(32'h77 + c); upd_idx = 6'd0;
      end else begin
        lookup_en = 1'b1; tag = 53'h123; idx = 6'd5;
      end
      tick();
      upd_en = 1'b0; lookup_en = 1'b0;
      if (enable_o) saw_en = 1'b1;
      if (busy_o) cnt++;
    end
    $display("txn sweep busy_cycles=%0d", cnt);
    chk("sweep.len",  64'(cnt),       64'(64));
    chk("sweep.en",   64'(saw_en),    64'(0));
    chk("sweep.done", 64'(busy_o),    64'(0));
    chk("sweep.uway", 64'(upd_way_o), 64'(SIXTH_WAY));

    lookup_chk("post_123", 53'h123, 6'd5, 1'b0, 2'd0);
    lookup_chk("post_t5",  53'd5,   6'd9, 1'b0, 2'd0);
    lookup_chk("post_t6",  53'd6,   6'd9, 1'b0, 2'd0);
    lookup_chk("post_55",  53'h55,  6'd30, 1'b0, 2'd0);
    lookup_chk("post_drop", 53'hB5, 6'd0, 1'b0, 2'd0);
    fill_chk("post_fill", 53'hABC, 6'd9, 2'd0);
    lookup_chk("post_hit", 53'hABC, 6'd9, 1'b1, 2'd0);

    // Asynchronous reset in the middle of a sweep
    inv_all = 1'b1;
    tick();
    inv_all = 1'b0;
    tick();
    chk("rsweep.busy", 64'(busy_o), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rsweep.abort", 64'(busy_o), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    chk("rsweep.idle", 64'(busy_o), 64'(0));
    lookup_chk("rsweep.miss", 53'hABC, 6'd9, 1'b0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
